// File: rtl/slice_write_arbiter_if.sv
// Requester-side bus of the slice write arbiter.
//
// Handshake: a requester raises req[k] with mode/idx/wdata of slot k stable and
// keeps them stable until it sees grant[k]; the transfer happens on the rising
// clock edge where req[k] & grant[k] is high. grant is combinational from req
// and the arbiter's round-robin pointer, and is at most one-hot.
interface slice_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int LEN  = 4,
  parameter int IDXW = 4
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      mode;
  logic [NREQ*IDXW-1:0] idx;
  logic [NREQ*LEN-1:0]  wdata;
  logic [NREQ-1:0]      grant;

  modport master (output req, output mode, output idx, output wdata, input grant);
  modport slave  (input req, input mode, input idx, input wdata, output grant);
endinterface

// File: rtl/slice_write_arbiter.sv
// Round-robin arbiter that serializes slice writes into one shared register.
// Stage 1 captures the winning request; stage 2 range-checks it and commits
// the slice (or flags err). clr wipes the register and discards that cycle's
// commit without stalling arbitration.
module slice_write_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int LEN   = 4,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  slice_write_arbiter_if.slave   bus,
  input  logic                   clr,
  output logic [WIDTH-1:0]       xs,
  output logic                   err,
  output logic [7:0]             wr_cnt
);

  localparam int RRW = $clog2(NREQ);

  // round-robin pointer and scan results
  logic [RRW-1:0]  rr;
  logic [RRW-1:0]  rr_next;
  logic [RRW-1:0]  win;
  logic            any;
  logic [NREQ-1:0] grant_c;
  int              scan_k;

  // captured request (stage 1)
  logic            p_vld;
  logic            p_mode;
  logic [IDXW-1:0] p_idx;
  logic [LEN-1:0]  p_data;

  // commit-side decode (stage 2)
  logic             p_ok;
  logic [IDXW-1:0]  lo;
  logic [WIDTH-1:0] dext;
  logic [WIDTH-1:0] mext;
  logic [WIDTH-1:0] xs_wr;

  // Scan from rr upward, wrapping, and grant the first active requester.
  always_comb begin
    grant_c = '0;
    win     = '0;
    any     = 1'b0;
    scan_k  = 0;
    for (int i = 0; i < NREQ; i++) begin
      scan_k = (int'(rr) + i) % NREQ;
      if (!any && bus.req[scan_k]) begin
        grant_c[scan_k] = 1'b1;
        win             = RRW'(scan_k);
        any             = 1'b1;
      end
    end
    if (int'(win) == NREQ - 1) rr_next = '0;
    else                       rr_next = win + RRW'(1);
  end

  assign bus.grant = grant_c;

  // Advance the pointer past the winner and capture its fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr     <= '0;
      p_vld  <= 1'b0;
      p_mode <= 1'b0;
      p_idx  <= '0;
      p_data <= '0;
    end else begin
      p_vld <= any;
      if (any) begin
        rr     <= rr_next;
        p_mode <= bus.mode[win];
        p_idx  <= bus.idx[int'(win)*IDXW +: IDXW];
        p_data <= bus.wdata[int'(win)*LEN +: LEN];
      end
    end
  end

  // Range check without wrap, then build the merged register value; the
  // lowest written bit is p_idx (ascending) or p_idx-(LEN-1) (descending).
  always_comb begin
    if (p_mode) p_ok = (int'(p_idx) >= LEN - 1) && (int'(p_idx) <= WIDTH - 1);
    else        p_ok = (int'(p_idx) + LEN <= WIDTH);
    lo = p_mode ? (p_idx - IDXW'(LEN - 1)) : p_idx;
    dext = '0;
    dext[LEN-1:0] = p_data;
    mext = '0;
    mext[LEN-1:0] = '1;
    xs_wr = (xs & ~(mext << lo)) | (dext << lo);
  end

  // Commit stage: clr wins over any commit; invalid commits pulse err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs     <= '0;
      wr_cnt <= '0;
      err    <= 1'b0;
    end else if (clr) begin
      xs  <= '0;
      err <= 1'b0;
    end else if (p_vld && p_ok) begin
      xs     <= xs_wr;
      wr_cnt <= wr_cnt + 8'd1;
      err    <= 1'b0;
    end else begin
      err <= p_vld;
    end
  end

endmodule

// File: tb/tb_slice_write_arbiter.sv
// Directed bench for slice_write_arbiter (WIDTH=16, NREQ=4, LEN=4).
// The driver pushes the hand-derived grant of every cycle and, one cycle
// later, the expected {xs, wr_cnt, err} of each commit; a monitor on the
// falling edge pops and compares.
module tb_slice_write_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int LEN   = 4;
  localparam int IDXW  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [WIDTH-1:0] xs;
  logic             err;
  logic [7:0]       wr_cnt;

  always #5 clk = ~clk;

  slice_write_arbiter_if #(.NREQ(NREQ), .LEN(LEN), .IDXW(IDXW)) bus ();

  slice_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LEN(LEN), .IDXW(IDXW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .clr    (clr),
    .xs     (xs),
    .err    (err),
    .wr_cnt (wr_cnt)
  );

  // scoreboard
  logic [NREQ-1:0] gnt_q[$];
  logic [24:0]     exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  // reference state
  logic [WIDTH-1:0] m_xs  = '0;
  logic [7:0]       m_cnt = '0;
  logic             pend  = 1'b0;
  logic             pm;
  logic [3:0]       pi;
  logic [3:0]       pd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: grant every cycle, commit result two falling edges after acceptance
  logic a1 = 1'b0;
  logic a2 = 1'b0;
  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    logic [24:0]     er;
    if (rst) begin
      a1 = 1'b0;
      a2 = 1'b0;
    end else begin
      if (gnt_q.size() > 0) begin
        eg = gnt_q.pop_front();
        chk("grant", {28'd0, bus.grant}, {28'd0, eg});
      end
      if (a2) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_underflow", 32'd1, 32'd0);
        end else begin
          er = exp_q.pop_front();
          chk("xs", {16'd0, xs}, {16'd0, er[24:9]});
          chk("wr_cnt", {24'd0, wr_cnt}, {24'd0, er[8:1]});
          chk("err", {31'd0, err}, {31'd0, er[0]});
        end
      end else begin
        chk("err_idle", {31'd0, err}, 32'd0);
      end
      a2 = a1;
      a1 = |(bus.req & bus.grant);
    end
  end

  // driver tasks
  task automatic set_req(input int k, input logic m, input logic [3:0] ix, input logic [3:0] d);
    bus.mode[k]          = m;
    bus.idx[k*IDXW +: IDXW] = ix;
    bus.wdata[k*LEN +: LEN] = d;
  endtask

  // One cycle: resolve the previous acceptance against this cycle's clr,
  // then present req/clr and the expected grant.
  task automatic step(input logic [3:0] r, input logic c, input logic [3:0] eg);
    int lo;
    logic ok;
    if (pend) begin
      if (c) begin
        exp_q.push_back({16'h0, m_cnt, 1'b0});
      end else begin
        ok = pm ? (int'(pi) >= 3) : (int'(pi) + 4 <= 16);
        if (ok) begin
          lo = pm ? int'(pi) - 3 : int'(pi);
          m_xs[lo +: 4] = pd;
          m_cnt = m_cnt + 8'd1;
          exp_q.push_back({m_xs, m_cnt, 1'b0});
        end else begin
          exp_q.push_back({m_xs, m_cnt, 1'b1});
        end
      end
      pend = 1'b0;
    end
    if (c) m_xs = '0;
    bus.req = r;
    clr     = c;
    gnt_q.push_back(eg);
    for (int k = 0; k < NREQ; k++) begin
      if (eg[k]) begin
        pend = 1'b1;
        pm   = bus.mode[k];
        pi   = bus.idx[k*IDXW +: IDXW];
        pd   = bus.wdata[k*LEN +: LEN];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    clr     = 1'b0;
    pend    = 1'b0;
    m_xs    = '0;
    m_cnt   = '0;
    #1;
    chk("rst_xs", {16'd0, xs}, 32'd0);
    chk("rst_wr_cnt", {24'd0, wr_cnt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_grant", {28'd0, bus.grant}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req   = '0;
    bus.mode  = '0;
    bus.idx   = '0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // both index forms
    set_req(0, 1'b0, 4'd4, 4'hA);
    step(4'b0001, 1'b0, 4'b0001);
    set_req(1, 1'b1, 4'd15, 4'h5);
    step(4'b0010, 1'b0, 4'b0010);
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000);
    chk("both_forms_xs", {16'd0, xs}, 32'h50A0);
    chk("both_forms_cnt", {24'd0, wr_cnt}, 32'd2);

    // round-robin with everyone requesting; rr is 2 here
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, 4'(k*4), 4'(k+1));
    step(4'b1111, 1'b0, 4'b0100);
    step(4'b1111, 1'b0, 4'b1000);
    step(4'b1111, 1'b0, 4'b0001);
    step(4'b1111, 1'b0, 4'b0010);
    step(4'b1111, 1'b0, 4'b0100);
    // two requesters: 3, then 1, alternating
    step(4'b1010, 1'b0, 4'b1000);
    step(4'b1010, 1'b0, 4'b0010);
    step(4'b1010, 1'b0, 4'b1000);
    step(4'b1010, 1'b0, 4'b0010);
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000);
    chk("rr_xs", {16'd0, xs}, 32'h4321);
    chk("rr_cnt", {24'd0, wr_cnt}, 32'd11);

    // range check, then exact boundaries (rr is 2)
    set_req(0, 1'b0, 4'd13, 4'hF);
    step(4'b0001, 1'b0, 4'b0001);
    set_req(1, 1'b1, 4'd2, 4'hF);
    step(4'b0010, 1'b0, 4'b0010);
    set_req(2, 1'b0, 4'd12, 4'h9);
    step(4'b0100, 1'b0, 4'b0100);
    set_req(3, 1'b1, 4'd3, 4'h6);
    step(4'b1000, 1'b0, 4'b1000);
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000);
    chk("bound_xs", {16'd0, xs}, 32'h9326);
    chk("bound_cnt", {24'd0, wr_cnt}, 32'd13);

    // clr on the commit edge, with a back-to-back request behind it (rr is 0)
    set_req(0, 1'b0, 4'd0, 4'hF);
    step(4'b0001, 1'b0, 4'b0001);
    set_req(1, 1'b0, 4'd8, 4'hC);
    step(4'b0010, 1'b1, 4'b0010);
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000);
    chk("clr_xs", {16'd0, xs}, 32'h0C00);
    chk("clr_cnt", {24'd0, wr_cnt}, 32'd14);

    // reset with a captured write in flight (rr is 2)
    set_req(2, 1'b0, 4'd4, 4'h7);
    step(4'b0100, 1'b0, 4'b0100);
    do_reset();
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000);
    chk("post_rst_xs", {16'd0, xs}, 32'd0);
    chk("post_rst_cnt", {24'd0, wr_cnt}, 32'd0);

    // pointer is back at 0: from {3,2} requester 2 wins
    set_req(2, 1'b0, 4'd8, 4'h3);
    set_req(3, 1'b0, 4'd12, 4'h4);
    step(4'b1100, 1'b0, 4'b0100);

    // 255 more valid commits: 256 total wraps the counter to 0
    for (int i = 0; i < 255; i++) begin
      set_req(0, 1'b0, 4'((i % 4) * 4), 4'(i));
      step(4'b0001, 1'b0, 4'b0001);
    end
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000);
    chk("wrap_cnt", {24'd0, wr_cnt}, 32'd0);
    chk("wrap_err", {31'd0, err}, 32'd0);

    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("gnt_q_drained", gnt_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
